audio_dac_arbiter: RTL and testbench
====================================

# audio_dac_arbiter

Round-robin scheduler that shares the single audio DAC FIFO write port between `NUM_SRC` stereo sample producers (synth voices, CPU sample player). It accepts whole stereo pairs from requesters and writes them into the FIFO as Left then Right words, so channel alignment on the serial DAC side is never broken. The FIFO full flag throttles it. The block sits on the FIFO write-clock side, between the sample producers and the DAC FIFO slave.

## Interface
Parameters:
- `NUM_SRC`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 16: sample width; must equal the DAC FIFO word width.

Ports:
- `clk`  in  1  FIFO write-side clock. One clock; reset is synchronous and active-low.
- `reset_n`  in  1  synchronous active-low reset.
- `enable`  in  1  when low, no new pair is granted. A pair already in progress completes.
- `src_valid`  in  NUM_SRC  requester i has a stereo pair on offer. Must stay high, with stable data, until `src_ready[i]`.
- `src_left`  in  NUM_SRC*DATA_WIDTH  left samples; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_right`  in  NUM_SRC*DATA_WIDTH  right samples; same packing as `src_left`.
- `src_ready`  out  NUM_SRC  one-hot, one-cycle accept pulse.
- `fifo_writedata`  out  DATA_WIDTH  word to the FIFO.
- `fifo_write`  out  1  write strike, one word per cycle high.
- `fifo_full`  in  1  FIFO write-full flag (bit 0 of the FIFO slave readdata).
- `grant_id`  out  clog2(NUM_SRC)  index of the last granted requester.
- `pair_done`  out  1  one-cycle pulse in the cycle the Right word is written.

## Operation
- The FSM has three states: IDLE, WR_L, WR_R.
- IDLE:
  - Grant when `enable`=1, any `src_valid` is high, and `fifo_full`=0.
  - The grant goes to the first valid requester searching from `last+1` modulo NUM_SRC.
  - `src_ready[g]`=1 for that cycle only. `src_left`/`src_right` slice g is latched into the internal L/R registers.
  - `grant_id`<=g, `last`<=g, next state WR_L.
- WR_L:
  - If `fifo_full`=0: `fifo_write`=1, `fifo_writedata`=L, next state WR_R.
  - Otherwise hold the state with `fifo_write`=0.
- WR_R:
  - If `fifo_full`=0: `fifo_write`=1, `fifo_writedata`=R, `pair_done`=1, next state IDLE.
  - Otherwise hold the state.
- A pair is never split or dropped. Once granted, it is written completely, whatever `enable` does or how long the FIFO stays full.
- Only one requester is ever granted per pair. Requesters that are not granted see `src_ready`=0 and keep their valid high.
- Fairness: with all requesters valid continuously, grants rotate 0,1,…,NUM_SRC-1,0…
- `fifo_write`, `pair_done` and `src_ready` are combinational from the state, `fifo_full` and `src_valid`. `fifo_writedata` is driven from the L/R registers, and is L in IDLE.

## Timing
- Reset values:
  - state=IDLE.
  - `last`=NUM_SRC-1, so requester 0 has first priority.
  - `grant_id`=0, L/R=0.
  - `src_ready`=0, `fifo_write`=0, `pair_done`=0, `fifo_writedata`=0.
- Minimum latency: grant at cycle n, L write at n+1, R write plus `pair_done` at n+2, next grant at n+3. Peak throughput is one pair per 3 clocks.
- `fifo_full` is sampled in the same cycle as the write decision. A word is never presented while `fifo_full`=1.
- If `fifo_full` rises between L and R, the block stalls in WR_R. R is written in the first cycle `fifo_full`=0.
- `enable` falling in WR_L or WR_R has no effect until the block is back in IDLE.
- `src_valid` rising in WR_L or WR_R is ignored until IDLE.
- Reset mid-pair abandons the pair. The FIFO is cleared by the same reset, so no orphan L word survives.
- Width rule: `grant_id` and `last` are clog2(NUM_SRC) bits. The round-robin wraps modulo NUM_SRC, with no out-of-range index for non-power-of-2 NUM_SRC.

## Structure
- Shared package `audio_pkg`:
  - FSM state enum (IDLE/WR_L/WR_R).
  - Default `AUDIO_DATA_WIDTH`=16.
  - Helper function for slice extraction from the packed buses.
- Sub-module `rr_arbiter`: parameterised NUM_SRC. Inputs are request vector, `last` and `advance`; outputs are one-hot grant, grant index and `any_req`. This top handles only FSM, data latching and the FIFO port.

## Test plan
- Reset, then req 0 valid (L=16'h1234, R=16'h5678), full=0 → `src_ready[0]` at cycle 1, writes 1234 then 5678 on cycles 2 and 3, `pair_done` on cycle 3, `grant_id`=0.
- All 4 requesters valid continuously for 12 pairs → grant order 0,1,2,3 repeated 3 times; FIFO word stream strictly L,R alternating.
- Full held high for 10 cycles after the L write → no write during the stall; R written in the first cycle after full drops; total 2 writes.
- Full=1 in IDLE with req valid → no `src_ready`, no write; release full → grant next cycle.
- `enable` dropped in WR_L → pair completes (2 writes), then no further grants while requests remain valid.
- NUM_SRC=3, all valid → grants wrap 0,1,2,0 with `grant_id` never 3; reset asserted in WR_R → all outputs 0 the next cycle, next grant goes to requester 0.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio DAC arbiter.
// Holds the write FSM state enum, the default sample width and a helper
// that extracts requester slices from packed sample buses.
package audio_pkg;
  localparam int AUDIO_DATA_WIDTH = 16;
  localparam int MAX_SRC = 8;
  localparam int MAX_W = 32;
  localparam int MAX_BUS = MAX_SRC * MAX_W;
  typedef enum logic [1:0] {IDLE, WR_L, WR_R} state_e;
  // Caller widens its bus to MAX_BUS and truncates the result to its own width.
  function automatic logic [MAX_W-1:0] get_slice(input logic [MAX_BUS-1:0] bus, input int unsigned idx, input int unsigned w);
    logic [MAX_BUS-1:0] s;
    s = bus >> (idx * w);
    return s[MAX_W-1:0];
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting after the last grant.
// Ports: req_i request vector, last_i previous winner, advance_i allows a grant;
//        gnt_o one-hot grant, gnt_idx_o winner index, any_req_o any request high.
module rr_arbiter #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] last_i,
  input  logic                       advance_i,
  output logic [NUM_SRC-1:0]         gnt_o,
  output logic [$clog2(NUM_SRC)-1:0] gnt_idx_o,
  output logic                       any_req_o
);
  localparam int IW = $clog2(NUM_SRC);
  logic [IW-1:0] cand;
  logic found;
  // Candidates wrap modulo NUM_SRC, so non-power-of-2 sizes never yield an out-of-range index.
  always_comb begin
    gnt_idx_o = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IW'((int'(last_i) + k) % NUM_SRC);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        gnt_idx_o = cand;
      end
    end
  end
  assign any_req_o = |req_i;
  assign gnt_o = (advance_i && any_req_o) ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << gnt_idx_o) : '0;
endmodule

// File: rtl/audio_dac_arbiter.sv
// audio_dac_arbiter: round-robin share of the DAC FIFO write port, whole stereo pairs.
// Ports: clk/reset_n (sync active-low), enable gates new grants;
//        src_valid/src_left/src_right requester pairs, src_ready one-cycle accept;
//        fifo_writedata/fifo_write/fifo_full FIFO write port;
//        grant_id last granted requester, pair_done pulse on the Right write.
module audio_dac_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_WIDTH = AUDIO_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_left,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_right,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         fifo_writedata,
  output logic                          fifo_write,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_SRC)-1:0]    grant_id,
  output logic                          pair_done
);
  localparam int IW = $clog2(NUM_SRC);
  state_e state_q, state_d;
  logic [IW-1:0] last_q, grant_id_q, gnt_idx;
  logic [DATA_WIDTH-1:0] l_q, r_q, l_d, r_d;
  logic [MAX_BUS-1:0] left_ext, right_ext;
  logic advance, any_req, take;
  // Grants are gated by reset too, so src_ready stays low while reset is held.
  assign advance = reset_n && enable && !fifo_full && state_q == IDLE;
  assign take = advance && any_req;
  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req_i(src_valid),
    .last_i(last_q),
    .advance_i(advance),
    .gnt_o(src_ready),
    .gnt_idx_o(gnt_idx),
    .any_req_o(any_req)
  );
  assign left_ext = MAX_BUS'(src_left);
  assign right_ext = MAX_BUS'(src_right);
  assign l_d = DATA_WIDTH'(get_slice(left_ext, int'(gnt_idx), DATA_WIDTH));
  assign r_d = DATA_WIDTH'(get_slice(right_ext, int'(gnt_idx), DATA_WIDTH));
  assign grant_id = grant_id_q;
  always_comb begin
    state_d = state_q;
    fifo_write = 1'b0;
    pair_done = 1'b0;
    fifo_writedata = l_q;
    case (state_q)
      IDLE: state_d = take ? WR_L : IDLE;
      WR_L: begin
        fifo_write = !fifo_full;
        state_d = fifo_full ? WR_L : WR_R;
      end
      WR_R: begin
        fifo_write = !fifo_full;
        pair_done = !fifo_full;
        fifo_writedata = r_q;
        state_d = fifo_full ? WR_R : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q <= IW'(NUM_SRC - 1);
      grant_id_q <= '0;
      l_q <= '0;
      r_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        last_q <= gnt_idx;
        grant_id_q <= gnt_idx;
        l_q <= l_d;
        r_q <= r_d;
      end
    end
  end
endmodule

// File: tb/tb_audio_dac_arbiter.sv
// tb_audio_dac_arbiter: directed table plus hand sequences for the DAC arbiter.
module tb_audio_dac_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, enable, fifo_full;
  logic [3:0] src_valid, src_ready;
  logic [63:0] src_left, src_right;
  logic [15:0] fifo_writedata;
  logic fifo_write, pair_done;
  logic [1:0] grant_id;
  logic rst3_n;
  logic [2:0] valid3, ready3;
  logic [47:0] left3, right3;
  logic [15:0] wd3;
  logic wr3, done3;
  logic [1:0] gid3;
  audio_dac_arbiter #(.NUM_SRC(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .src_valid(src_valid),
    .src_left(src_left), .src_right(src_right), .src_ready(src_ready),
    .fifo_writedata(fifo_writedata), .fifo_write(fifo_write), .fifo_full(fifo_full),
    .grant_id(grant_id), .pair_done(pair_done)
  );
  audio_dac_arbiter #(.NUM_SRC(3), .DATA_WIDTH(16)) dut3 (
    .clk(clk), .reset_n(rst3_n), .enable(enable), .src_valid(valid3),
    .src_left(left3), .src_right(right3), .src_ready(ready3),
    .fifo_writedata(wd3), .fifo_write(wr3), .fifo_full(fifo_full),
    .grant_id(gid3), .pair_done(done3)
  );
  typedef struct {
    logic rst_n, en, full;
    logic [3:0] valid;
    logic [3:0] ready;
    logic wr;
    logic [15:0] data;
    logic done;
    logic [1:0] gid;
  } vec_t;
  vec_t tbl[$];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  initial begin
    int nw;
    int g[$];
    logic [15:0] w[$];
    src_left = {16'hA003, 16'hA002, 16'hA001, 16'h1234};
    src_right = {16'hB003, 16'hB002, 16'hB001, 16'h5678};
    left3 = {16'hC002, 16'hC001, 16'hC000};
    right3 = {16'hD002, 16'hD001, 16'hD000};
    reset_n = 1'b0; enable = 1'b1; fifo_full = 1'b0; src_valid = '0;
    rst3_n = 1'b0; valid3 = '0;
    //             rst en full valid    ready    wr data      done gid
    tbl.push_back('{0, 1, 0, 4'b1111, 4'b0000, 0, 16'h0000, 0, 0});
    tbl.push_back('{1, 1, 0, 4'b0001, 4'b0001, 0, 16'h0000, 0, 0});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 1, 16'h1234, 0, 0});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 1, 16'h5678, 1, 0});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 0, 16'h1234, 0, 0});
    tbl.push_back('{1, 1, 1, 4'b0010, 4'b0000, 0, 16'h1234, 0, 0});
    tbl.push_back('{1, 1, 1, 4'b0010, 4'b0000, 0, 16'h1234, 0, 0});
    tbl.push_back('{1, 1, 0, 4'b0010, 4'b0010, 0, 16'h1234, 0, 0});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 1, 16'hA001, 0, 1});
    tbl.push_back('{1, 1, 1, 4'b0000, 4'b0000, 0, 16'hB001, 0, 1});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 1, 16'hB001, 1, 1});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 0, 16'hA001, 0, 1});
    tbl.push_back('{1, 1, 0, 4'b1000, 4'b1000, 0, 16'hA001, 0, 1});
    tbl.push_back('{1, 0, 0, 4'b0100, 4'b0000, 1, 16'hA003, 0, 3});
    tbl.push_back('{1, 0, 0, 4'b0100, 4'b0000, 1, 16'hB003, 1, 3});
    tbl.push_back('{1, 0, 0, 4'b0100, 4'b0000, 0, 16'hA003, 0, 3});
    tbl.push_back('{1, 0, 0, 4'b0100, 4'b0000, 0, 16'hA003, 0, 3});
    tbl.push_back('{1, 1, 0, 4'b0101, 4'b0001, 0, 16'hA003, 0, 3});
    tbl.push_back('{1, 1, 0, 4'b0100, 4'b0000, 1, 16'h1234, 0, 0});
    tbl.push_back('{1, 1, 0, 4'b0100, 4'b0000, 1, 16'h5678, 1, 0});
    tbl.push_back('{1, 1, 0, 4'b0100, 4'b0100, 0, 16'h1234, 0, 0});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 1, 16'hA002, 0, 2});
    tbl.push_back('{1, 1, 0, 4'b0000, 4'b0000, 1, 16'hB002, 1, 2});
    repeat (2) @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset_n = tbl[i].rst_n; enable = tbl[i].en; fifo_full = tbl[i].full; src_valid = tbl[i].valid;
      #1;
      chk($sformatf("row%0d_ready", i), src_ready, tbl[i].ready);
      chk($sformatf("row%0d_write", i), fifo_write, tbl[i].wr);
      chk($sformatf("row%0d_data", i), fifo_writedata, tbl[i].data);
      chk($sformatf("row%0d_done", i), pair_done, tbl[i].done);
      chk($sformatf("row%0d_gid", i), grant_id, tbl[i].gid);
    end
    // long FIFO stall between L and R
    @(negedge clk); reset_n = 1'b0; src_valid = '0; fifo_full = 1'b0; enable = 1'b1;
    @(negedge clk); reset_n = 1'b1; src_valid = 4'b0001;
    #1 chk("stall_grant", src_ready, 4'b0001);
    nw = 0;
    @(negedge clk); src_valid = '0;
    #1 chk("stall_L_write", fifo_write, 1); chk("stall_L_data", fifo_writedata, 16'h1234);
    nw += int'(fifo_write);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); fifo_full = 1'b1;
      #1 chk($sformatf("stall_hold%0d", i), {fifo_write, pair_done}, 2'b00);
      nw += int'(fifo_write);
    end
    @(negedge clk); fifo_full = 1'b0;
    #1 chk("stall_R_write", fifo_write, 1); chk("stall_R_data", fifo_writedata, 16'h5678);
    chk("stall_R_done", pair_done, 1);
    nw += int'(fifo_write);
    repeat (2) begin
      @(negedge clk); #1 nw += int'(fifo_write);
    end
    chk("stall_total_writes", nw, 2);
    // all four requesters valid continuously
    @(negedge clk); reset_n = 1'b0; src_valid = '0;
    @(negedge clk); reset_n = 1'b1; src_valid = 4'b1111;
    for (int c = 0; c < 36; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("rr_onehot%0d", c), $countones(src_ready) <= 1, 1);
      for (int k = 0; k < 4; k++) if (src_ready[k]) g.push_back(k);
      if (fifo_write) w.push_back(fifo_writedata);
    end
    chk("rr_grant_count", g.size(), 12);
    chk("rr_word_count", w.size(), 24);
    for (int i = 0; i < g.size() && i < 12; i++) chk($sformatf("rr_grant%0d", i), g[i], i % 4);
    for (int j = 0; j < w.size() && j < 24; j++)
      chk($sformatf("rr_word%0d", j), w[j], (j % 2 == 0) ? src_left[((j / 2) % 4) * 16 +: 16] : src_right[((j / 2) % 4) * 16 +: 16]);
    // three-requester instance: wrap and reset mid-pair
    @(negedge clk); src_valid = '0; valid3 = 3'b111; rst3_n = 1'b0;
    g.delete();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); rst3_n = 1'b1;
      #1;
      chk($sformatf("n3_gid_range%0d", c), gid3 < 2'd3, 1);
      for (int k = 0; k < 3; k++) if (ready3[k]) g.push_back(k);
    end
    chk("n3_grant_count", g.size(), 4);
    for (int i = 0; i < g.size() && i < 4; i++) chk($sformatf("n3_grant%0d", i), g[i], (i == 3) ? 0 : i);
    @(negedge clk); #1 chk("n3_grant_after_wrap", ready3, 3'b010);
    @(negedge clk);
    @(negedge clk); #1 chk("n3_in_wr_r", {wr3, done3, wd3}, {1'b1, 1'b1, 16'hD001});
    rst3_n = 1'b0;
    @(negedge clk); #1;
    chk("n3_rst_ready", ready3, 0);
    chk("n3_rst_write", wr3, 0);
    chk("n3_rst_done", done3, 0);
    chk("n3_rst_data", wd3, 0);
    chk("n3_rst_gid", gid3, 0);
    @(negedge clk); rst3_n = 1'b1;
    #1 chk("n3_first_after_rst", ready3, 3'b001);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
